// File: rtl/alu_pkg.sv
// Shared ALU package: M-extension op encoding, multiply/divide state encoding
// and the ALU control codes the decoder uses to route ops to alu_muldiv.
package alu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIXUP,
        S_DONE
    } muldiv_state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MULDIV
    } alu_ctrl_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the magnitude datapath on the 2W accumulator:
// shift-add for multiply, shift and restoring trial-subtract for divide.
module alu_muldiv_step #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next
);

    logic [W:0]   sum;
    logic [W:0]   trial;
    logic [2*W:0] shifted;

    // trial[W] set means the shifted remainder was smaller than the divisor
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc, 1'b0};
        trial    = shifted[2*W:W] - {1'b0, operand};
        acc_next = {sum, acc[W-1:1]};
        if (is_div) begin
            acc_next = shifted[2*W-1:0];
            if (!trial[W]) begin
                acc_next = {trial[W-1:0], shifted[W-1:1], 1'b1};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Optional ALU_MULDIV_EARLY_OUT_EN short-cuts trivial and special-case ops in PREP.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         N_flag,
    output logic         Z_flag
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    muldiv_state_e  state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic           sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           n_q, n_d, z_q, z_d;

    logic [2*W-1:0] step_acc;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mag_a, mag_b, quo, rem, res_fix;
    logic           sa, sb;

    alu_muldiv_step #(.W(W)) u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (step_acc)
    );

`ifdef ALU_MULDIV_EARLY_OUT_EN
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic         early_hit;
    logic [W-1:0] early_val;

    always_comb begin
        early_hit = 1'b0;
        early_val = '0;
        if (op_is_div(op_q)) begin
            if (b_q == '0) begin
                early_hit = 1'b1;
                early_val = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
            end else if (((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_VAL) && (b_q == '1)) begin
                early_hit = 1'b1;
                early_val = (op_q == OP_DIV) ? MIN_VAL : '0;
            end
        end else if ((a_q == '0) || (b_q == '0)) begin
            early_hit = 1'b1;
        end
    end
`endif

    // Divide-by-zero keeps the all-ones quotient even for a negative dividend
    always_comb begin
        sa    = op_signed_a(op_q) && a_q[W-1];
        sb    = op_signed_b(op_q) && b_q[W-1];
        mag_a = sa ? -a_q : a_q;
        mag_b = sb ? -b_q : b_q;
        prod  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo   = acc_q[W-1:0];
        rem   = acc_q[2*W-1:W];
        if (op_is_div(op_q)) begin
            if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                res_fix = ((sign_a_q ^ sign_b_q) && (opnd_q != '0)) ? -quo : quo;
            end else begin
                res_fix = sign_a_q ? -rem : rem;
            end
        end else begin
            res_fix = (op_q == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sign_a_d = sa;
                sign_b_d = sb;
                cnt_d    = CNT_LAST;
                if (op_is_div(op_q)) begin
                    acc_d  = {{W{1'b0}}, mag_a};
                    opnd_d = mag_b;
                end else begin
                    acc_d  = {{W{1'b0}}, mag_b};
                    opnd_d = mag_a;
                end
                state_d = S_CALC;
`ifdef ALU_MULDIV_EARLY_OUT_EN
                if (early_hit) begin
                    result_d = early_val;
                    n_d      = early_val[W-1];
                    z_d      = (early_val == '0);
                    state_d  = S_DONE;
                end
`endif
            end
            S_CALC: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIXUP: begin
                result_d = res_fix;
                n_d      = res_fix[W-1];
                z_d      = (res_fix == '0);
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign N_flag    = n_q;
    assign Z_flag    = z_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised and directed bench for alu_muldiv at W=8 against an arithmetic
// reference model; latency expectation follows ALU_MULDIV_EARLY_OUT_EN.
`timescale 1ns/1ps
module tb_alu_muldiv;

   localparam int W = 8;

   typedef struct {
      logic [2:0] o;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] e;
      string      name;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         N_flag;
   logic         Z_flag;

   int numChecks = 0;
   int numFails  = 0;

   vec_t dirVecs[$];

   alu_muldiv #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .N_flag    (N_flag),
      .Z_flag    (Z_flag)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      numChecks++;
      if (got !== exp) begin
         numFails++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // RV32M semantics scaled to 8 bits, written with plain integer arithmetic
   function automatic logic [7:0] refModel(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      longint sx, sy, ux, uy, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'(x);
      uy = longint'(y);
      r  = 0;
      case (o)
         3'd0: r = ux * uy;
         3'd1: r = (sx * sy) >>> 8;
         3'd2: r = (sx * uy) >>> 8;
         3'd3: r = (ux * uy) >> 8;
         3'd4: r = (uy == 0) ? -1 : ((sx == -128 && sy == -1) ? -128 : sx / sy);
         3'd5: r = (uy == 0) ? 255 : ux / uy;
         3'd6: r = (uy == 0) ? sx : ((sx == -128 && sy == -1) ? 0 : sx % sy);
         default: r = (uy == 0) ? ux : ux % uy;
      endcase
      return r[7:0];
   endfunction

   // Request-to-result latency counted from the accepting edge, inclusive
   function automatic int expLatency(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
`ifdef ALU_MULDIV_EARLY_OUT_EN
      if (o[2]) begin
         if (y == 8'h00) return 2;
         if ((o == 3'd4 || o == 3'd6) && x == 8'h80 && y == 8'hFF) return 2;
      end else if (x == 8'h00 || y == 8'h00) begin
         return 2;
      end
`endif
      return W + 3;
   endfunction

   // Issue one request, check latency, result, flags, optional back-pressure, then hand off
   task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] exp, input string tag, input int hold);
      int cyc;
      logic [7:0] held;
      @(negedge clk);
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      cyc      = 0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput($sformatf("%s.ready", tag), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc      = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput($sformatf("%s.latency", tag), 64'(cyc), 64'(expLatency(o, x, y)));
      checkOutput($sformatf("%s.result", tag), 64'(result), 64'(exp));
      checkOutput($sformatf("%s.N", tag), 64'(N_flag), 64'(exp[7]));
      checkOutput($sformatf("%s.Z", tag), 64'(Z_flag), 64'(exp == 8'h00));
      held = exp;
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         op       = 3'd3;
         a        = 8'h11;
         b        = 8'h22;
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s.hold%0d.result", tag, k), 64'(result), 64'(held));
         checkOutput($sformatf("%s.hold%0d.flags", tag, k), 64'({N_flag, Z_flag}), 64'({held[7], held == 8'h00}));
         checkOutput($sformatf("%s.hold%0d.busy", tag, k), 64'({in_ready, out_valid}), 64'b01);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput($sformatf("%s.release", tag), 64'({in_ready, out_valid}), 64'b10);
   endtask

   // Directed vectors, randomised traffic, back-pressure and mid-operation reset
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 3'd0;
      a         = '0;
      b         = '0;
      #1;
      checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset.result", 64'(result), 64'd0);
      checkOutput("reset.flags", 64'({N_flag, Z_flag}), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      dirVecs.push_back('{3'd0, 8'h07, 8'h06, 8'h2A, "MUL_7x6"});
      dirVecs.push_back('{3'd1, 8'h80, 8'h80, 8'h40, "MULH_80x80"});
      dirVecs.push_back('{3'd3, 8'hFF, 8'hFF, 8'hFE, "MULHU_FFxFF"});
      dirVecs.push_back('{3'd2, 8'hFF, 8'hFF, 8'hFF, "MULHSU_FFxFF"});
      dirVecs.push_back('{3'd4, 8'hF9, 8'h02, 8'hFD, "DIV_F9_02"});
      dirVecs.push_back('{3'd6, 8'hF9, 8'h02, 8'hFF, "REM_F9_02"});
      dirVecs.push_back('{3'd5, 8'hF9, 8'h02, 8'h7C, "DIVU_F9_02"});
      dirVecs.push_back('{3'd5, 8'h2A, 8'h00, 8'hFF, "DIVU_2A_00"});
      dirVecs.push_back('{3'd7, 8'h2A, 8'h00, 8'h2A, "REMU_2A_00"});
      dirVecs.push_back('{3'd4, 8'h80, 8'hFF, 8'h80, "DIV_ovf"});
      dirVecs.push_back('{3'd6, 8'h80, 8'hFF, 8'h00, "REM_ovf"});
      dirVecs.push_back('{3'd4, 8'hF9, 8'h00, 8'hFF, "DIV_neg_by0"});
      dirVecs.push_back('{3'd6, 8'hF9, 8'h00, 8'hF9, "REM_neg_by0"});
      dirVecs.push_back('{3'd0, 8'h00, 8'h5A, 8'h00, "MUL_zero"});

      foreach (dirVecs[i]) begin
         applyStimulus(dirVecs[i].o, dirVecs[i].x, dirVecs[i].y, dirVecs[i].e, dirVecs[i].name, 0);
      end

      applyStimulus(3'd0, 8'h07, 8'h06, 8'h2A, "MUL_backpressure", 5);

      for (int n = 0; n < 60; n++) begin
         logic [2:0] ro;
         logic [7:0] rx, ry;
         logic [7:0] specials [4];
         specials[0] = 8'h00;
         specials[1] = 8'h80;
         specials[2] = 8'hFF;
         specials[3] = 8'h01;
         ro = 3'($urandom_range(0, 7));
         rx = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 8'($urandom);
         ry = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 8'($urandom);
         applyStimulus(ro, rx, ry, refModel(ro, rx, ry), $sformatf("rand%0d_op%0d_%02h_%02h", n, ro, rx, ry),
                       ($urandom_range(0, 3) == 0) ? 2 : 0);
      end

      applyStimulus(3'd7, 8'h2A, 8'h00, 8'h2A, "REMU_pre_reset", 0);

      @(negedge clk);
      op       = 3'd4;
      a        = 8'hF9;
      b        = 8'h02;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midcalc_reset.in_ready", 64'(in_ready), 64'd1);
      checkOutput("midcalc_reset.out_valid", 64'(out_valid), 64'd0);
      checkOutput("midcalc_reset.result", 64'(result), 64'd0);
      checkOutput("midcalc_reset.flags", 64'({N_flag, Z_flag}), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(3'd0, 8'h03, 8'h05, 8'h0F, "MUL_after_reset", 0);

      $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide unit extending the single-cycle integer ALU with the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the ALU in the execute stage and stalls the pipeline through a valid/ready handshake. Operands are processed as magnitudes by an iterative one-bit-per-cycle shift-add / restoring-subtract datapath, with a final sign fix-up. Results carry N/Z flags with the same meaning as the ALU flags.

## Interface
- W, 32: operand and result width; legal range 4..64.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request; equals (state==IDLE); reset value 1.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  W  operand 1 (dividend / multiplicand).
- b  in  W  operand 2 (divisor / multiplier).
- out_valid  out  1  result available; reset value 0.
- out_ready  in  1  consumer accepts the result.
- result  out  W  registered result; reset value 0.
- N_flag  out  1  result[W-1], registered with result; reset value 0.
- Z_flag  out  1  result==0, registered with result; reset value 0.

## Operation
- States: IDLE -> PREP -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE: on in_valid && in_ready, latch op, a, b; go to PREP.
- PREP: record operand signs per op (MULH/DIV/REM: both signed; MULHSU: a signed only; others unsigned); take magnitudes; clear the 2W accumulator; load iteration counter with W-1; go to CALC.
- CALC: one iteration per cycle for W cycles. Multiply: if the multiplier LSB is set, add the multiplicand into the upper half; shift right. Divide: shift the remainder:quotient pair left, trial-subtract the divisor, and keep the result if non-negative (setting quotient bit 1). Leave when the counter reaches 0.
- FIXUP: negate the product if the operand signs differ. Negate the quotient if the signs differ; negate the remainder if the dividend is negative. Select the low or high word per op. Register result and flags; go to DONE.
- DONE: out_valid=1; result and flags stable. On out_ready go to IDLE.
- Divide by zero: DIV/DIVU return all ones; REM/REMU return a.
- Signed overflow (DIV with a=MIN, b=-1): DIV returns MIN; REM returns 0.
- Both special cases come out of the normal iteration with the fix-up rules above. No exception is raised.
- All arithmetic is modulo 2W internally. Only W bits are output.
- Reset at any time, including mid-CALC: state goes to IDLE, the in-flight operation is discarded, and outputs take their reset values.

## Timing
- Accepting edge = T0. PREP at T0..T1, CALC for W cycles, FIXUP for 1 cycle.
- out_valid rises after edge T0+W+2, i.e. W+3 cycles from request to result.
- in_ready is low from T0+1 until the edge after the out_valid && out_ready handshake.
- Minimum request-to-request spacing is W+4 cycles.
- in_valid while busy is ignored. The requester must hold its request until in_ready.
- If out_ready is held low, DONE persists indefinitely with no change to outputs.

## Configuration
- ALU_MULDIV_EARLY_OUT_EN defined: PREP detects b==0 on divides, DIV overflow, and a==0 or b==0 on multiplies. In those cases it writes the special result directly and goes to DONE, so out_valid rises 2 cycles after the request.
- ALU_MULDIV_EARLY_OUT_EN undefined: every op takes exactly W+3 cycles. Results are identical either way.

## Structure
- Shared package alu_pkg holds:
  - op encoding localparams (OP_MUL..OP_REMU);
  - the state encoding;
  - the ALU control codes, so the decoder can route M-extension ops here.
- One sub-module: alu_muldiv_step, a combinational single-iteration datapath (shift-add or shift-subtract on the 2W accumulator), instantiated once inside CALC.

## Test plan (W=8)
- MUL a=0x07 b=0x06 -> result 0x2A, N=0 Z=0; out_valid exactly 11 cycles after acceptance (2 cycles with EARLY_OUT_EN is not applicable here).
- MULH 0x80*0x80 -> 0x40; MULHU 0xFF*0xFF -> 0xFE; MULHSU 0xFF*0xFF -> 0xFF with N=1.
- DIV 0xF9/0x02 -> 0xFD; REM 0xF9/0x02 -> 0xFF; DIVU 0xF9/0x02 -> 0x7C.
- DIVU 0x2A/0x00 -> 0xFF, N=1; REMU 0x2A/0x00 -> 0x2A. DIV 0x80/0xFF -> 0x80; REM 0x80/0xFF -> 0x00 with Z=1. Latency is 2 cycles with EARLY_OUT_EN and 11 cycles without.
- Hold out_ready low for 5 cycles after out_valid -> result and flags unchanged and in_ready stays 0. A new in_valid during that window is ignored.
- Assert rst mid-CALC on a DIV -> in_ready=1, out_valid=0, result=0 immediately. A following MUL 0x03*0x05 returns 0x0F.
